// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised FIFO family: pointer width helper and default sizes.
package fifo_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    // Pointer width including the wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: increments on inc, cleared by async active-high reset.
module fifo_ptr #(
    parameter int unsigned PW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with programmable partial flags, occupancy and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output (combinational DOUT).
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH     = FIFO_DEPTH_DEF,
    parameter int unsigned AE_THRESH = 4,
    parameter int unsigned AF_THRESH = 12
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [WIDTH-1:0]        DIN,
    input  logic                    WE,
    input  logic                    RE,
    output logic [WIDTH-1:0]        DOUT,
    output logic                    EF,
    output logic                    PEF,
    output logic                    PFF,
    output logic                    FF,
    output logic [ptr_w(DEPTH)-1:0] COUNT,
    output logic                    OVF,
    output logic                    UDF
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [PW-1:0]    wAdd;
    logic [PW-1:0]    rAdd;
    logic             weOk;
    logic             reOk;
    logic [WIDTH-1:0] mem [DEPTH];

    // Occupancy is the modular pointer difference; the wrap bit disambiguates full from empty.
    assign COUNT = wAdd - rAdd;
    assign EF    = (COUNT == '0);
    assign FF    = (COUNT == PW'(DEPTH));
    assign PEF   = (COUNT <= PW'(AE_THRESH));
    assign PFF   = (COUNT >= PW'(AF_THRESH));

    assign weOk = WE & ~FF;
    assign reOk = RE & ~EF;

    fifo_ptr #(.PW(PW)) uWPtr (
        .clk (CLK),
        .rst (RESET),
        .inc (weOk),
        .ptr (wAdd)
    );

    fifo_ptr #(.PW(PW)) uRPtr (
        .clk (CLK),
        .rst (RESET),
        .inc (reOk),
        .ptr (rAdd)
    );

    always_ff @(posedge CLK) begin
        if (weOk) begin
            mem[wAdd[AW-1:0]] <= DIN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OVF <= 1'b0;
            UDF <= 1'b0;
        end else begin
            OVF <= WE & FF;
            UDF <= RE & EF;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown whenever data is present; RE only pops it.
    assign DOUT = EF ? '0 : mem[rAdd[AW-1:0]];
`else
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DOUT <= '0;
        end else if (reOk) begin
            DOUT <= mem[rAdd[AW-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Scoreboard bench for fifo_param: default 16x8 instance and a 4x16 sweep instance against a queue model.
module tb_fifo_param;

    localparam int unsigned D0 = 16;
    localparam int unsigned D1 = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din0, dout0;
    logic        we0, re0, ef0, pef0, pff0, ff0, ovf0, udf0;
    logic [4:0]  count0;
    logic [15:0] din1, dout1;
    logic        we1, re1, ef1, pef1, pff1, ff1, ovf1, udf1;
    logic [2:0]  count1;

    typedef struct {
        int d;
        int dout;
        int count;
        bit ovf;
        bit udf;
    } exp_t;

    exp_t expQ[$];
    int   m0[$];
    int   m1[$];
    int   lastDout [2];
    int   nTests = 0;
    int   nFail  = 0;

    fifo_param uDut0 (
        .CLK(clk), .RESET(rst), .DIN(din0), .WE(we0), .RE(re0), .DOUT(dout0),
        .EF(ef0), .PEF(pef0), .PFF(pff0), .FF(ff0), .COUNT(count0), .OVF(ovf0), .UDF(udf0)
    );

    fifo_param #(.WIDTH(16), .DEPTH(4), .AE_THRESH(1), .AF_THRESH(3)) uDut1 (
        .CLK(clk), .RESET(rst), .DIN(din1), .WE(we1), .RE(re1), .DOUT(dout1),
        .EF(ef1), .PEF(pef1), .PFF(pff1), .FF(ff1), .COUNT(count1), .OVF(ovf1), .UDF(udf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected response per driven cycle, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        int   ae, af, dep;
        #1;
        if (expQ.size() > 0) begin
            e   = expQ.pop_front();
            ae  = (e.d != 0) ? 1 : 4;
            af  = (e.d != 0) ? 3 : 12;
            dep = (e.d != 0) ? D1 : D0;
            if (e.d == 0) begin
                chk("dut0.dout",  32'(dout0),  e.dout);
                chk("dut0.count", 32'(count0), e.count);
                chk("dut0.ef",    32'(ef0),    32'(e.count == 0));
                chk("dut0.pef",   32'(pef0),   32'(e.count <= ae));
                chk("dut0.pff",   32'(pff0),   32'(e.count >= af));
                chk("dut0.ff",    32'(ff0),    32'(e.count == dep));
                chk("dut0.ovf",   32'(ovf0),   32'(e.ovf));
                chk("dut0.udf",   32'(udf0),   32'(e.udf));
            end else begin
                chk("dut1.dout",  32'(dout1),  e.dout);
                chk("dut1.count", 32'(count1), e.count);
                chk("dut1.ef",    32'(ef1),    32'(e.count == 0));
                chk("dut1.pef",   32'(pef1),   32'(e.count <= ae));
                chk("dut1.pff",   32'(pff1),   32'(e.count >= af));
                chk("dut1.ff",    32'(ff1),    32'(e.count == dep));
                chk("dut1.ovf",   32'(ovf1),   32'(e.ovf));
                chk("dut1.udf",   32'(udf1),   32'(e.udf));
            end
        end
    end

    // Drive one cycle on instance d and push the model's expected post-edge response.
    task automatic step(input int d, input bit we, input bit re, input int din);
        int   dep, sz, v;
        bit   wa, ra;
        exp_t e;
        @(negedge clk);
        if (d == 0) begin
            we0 = we; re0 = re; din0 = 8'(din); we1 = 1'b0; re1 = 1'b0;
            sz = m0.size();
        end else begin
            we1 = we; re1 = re; din1 = 16'(din); we0 = 1'b0; re0 = 1'b0;
            sz = m1.size();
        end
        dep   = (d != 0) ? D1 : D0;
        wa    = we && (sz < dep);
        ra    = re && (sz > 0);
        e.d   = d;
        e.ovf = we && (sz == dep);
        e.udf = re && (sz == 0);
        if (ra) begin
            v = (d != 0) ? m1.pop_front() : m0.pop_front();
            lastDout[d] = v;
        end
        if (wa) begin
            if (d != 0) m1.push_back(din & 32'hFFFF);
            else        m0.push_back(din & 32'hFF);
        end
        sz      = (d != 0) ? m1.size() : m0.size();
        e.count = sz;
`ifdef FIFO_FWFT_EN
        e.dout = (sz == 0) ? 0 : ((d != 0) ? m1[0] : m0[0]);
`else
        e.dout = lastDout[d];
`endif
        expQ.push_back(e);
    endtask

    task automatic checkResetState();
        chk("rst.count0", 32'(count0), 0);
        chk("rst.ef0",    32'(ef0),    1);
        chk("rst.pef0",   32'(pef0),   1);
        chk("rst.ff0",    32'(ff0),    0);
        chk("rst.pff0",   32'(pff0),   0);
        chk("rst.dout0",  32'(dout0),  0);
        chk("rst.ovf0",   32'(ovf0),   0);
        chk("rst.udf0",   32'(udf0),   0);
        chk("rst.count1", 32'(count1), 0);
        chk("rst.dout1",  32'(dout1),  0);
    endtask

    // Reset asserted between edges must clear state without waiting for a clock.
    task automatic doReset();
        @(negedge clk);
        we0 = 1'b0; re0 = 1'b0; we1 = 1'b0; re1 = 1'b0;
        #2 rst = 1'b1;
        #1 checkResetState();
        m0.delete();
        m1.delete();
        lastDout = '{0, 0};
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic randomRun(input int d, input int cycles);
        int pw;
        for (int i = 0; i < cycles; i++) begin
            pw = ((i / 50) % 2 == 0) ? 75 : 25;
            step(d, $urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw), int'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1;
        we0 = 1'b0; re0 = 1'b0; din0 = '0;
        we1 = 1'b0; re1 = 1'b0; din1 = '0;
        lastDout = '{0, 0};
        #1 checkResetState();
        @(negedge clk);
        rst = 1'b0;

        // Fill, overflow, drain, underflow on the default instance.
        for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, i);
        repeat (2) step(0, 1'b1, 1'b0, 'hEE);
        for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1, 0);
        step(0, 1'b0, 1'b1, 0);
        step(0, 1'b0, 1'b0, 0);

        // Simultaneous traffic at half occupancy across pointer wrap.
        for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0, 8'h40 + i);
        for (int i = 0; i < 40; i++) step(0, 1'b1, 1'b1, 8'h48 + i);
        for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0, 8'h80 + i);
        repeat (3) step(0, 1'b1, 1'b1, 8'hC0);
        for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b1, 8'hD0 + i);
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 0);

        // Reset with data in flight, then confirm normal operation.
        for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0, 8'h10 + i);
        doReset();
        step(0, 1'b1, 1'b0, 8'hA5);
        step(0, 1'b0, 1'b1, 0);
        step(0, 1'b0, 1'b0, 0);

        randomRun(0, 600);

        // Small-geometry instance: fill past full, drain past empty, then random.
        for (int i = 0; i < 5; i++) step(1, 1'b1, 1'b0, 16'hB000 + i);
        for (int i = 0; i < 5; i++) step(1, 1'b0, 1'b1, 0);
        for (int i = 0; i < 10; i++) step(1, 1'b1, 1'b1, 16'hC000 + i);
        randomRun(1, 300);

        step(0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            nTests++;
            nFail++;
            $display("FAIL scoreboard: %0d expected responses never checked", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised single-clock synchronous FIFO; next generation of the 16x8 fixed FIFO.
- Width and depth are generic.
- Almost-empty and almost-full thresholds are programmable.
- Adds an occupancy count output and overflow/underflow error pulses.
- Used wherever a byte/word stream crosses between producer and consumer blocks in the same clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage words; power of two, >=4
AE_THRESH, 4, PEF asserted when COUNT <= AE_THRESH (0 < AE_THRESH < DEPTH)
AF_THRESH, 12, PFF asserted when COUNT >= AF_THRESH (0 < AF_THRESH < DEPTH)

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  asynchronous, active-high reset
DIN  in  WIDTH  write data
WE  in  1  write request
RE  in  1  read request
DOUT  out  WIDTH  read data
EF  out  1  empty flag (COUNT == 0)
PEF  out  1  partially-empty flag (COUNT <= AE_THRESH)
PFF  out  1  partially-full flag (COUNT >= AF_THRESH)
FF  out  1  full flag (COUNT == DEPTH)
COUNT  out  clog2(DEPTH)+1  words currently stored
OVF  out  1  overflow pulse: write rejected
UDF  out  1  underflow pulse: read rejected

Behaviour:
Reset:
- One clock (CLK); reset is asynchronous and active-high (RESET). Asserting it immediately clears all of the following:
  - WADD and RADD pointers and COUNT to 0
  - DOUT to 0; OVF and UDF to 0
- During and after reset: EF=1, PEF=1, FF=0, PFF=0.
- Memory contents are not reset.
- Reset mid-operation discards all stored data. The first edge after deassertion behaves as for an empty FIFO.

Pointers:
- WADD and RADD are clog2(DEPTH)+1 bits. The low bits address memory; the MSB is the wrap bit.
- COUNT = WADD - RADD, modulo 2^(clog2(DEPTH)+1).
- Pointers wrap naturally from DEPTH-1 to 0 in their address bits.

Accept rules (same edge):
- Write accepted iff WE & ~FF: mem[WADD] <= DIN, WADD+1.
- Read accepted iff RE & ~EF: RADD+1.
- Full with WE & RE: read accepted, write rejected (OVF pulses).
- Empty with WE & RE: write accepted, read rejected (UDF pulses).
- Both accepted: COUNT unchanged; data ordering preserved.

Flags and errors:
- EF, PEF, PFF and FF are combinational from registered COUNT, so they update in the cycle after the accepting edge.
- OVF is registered: 1 for exactly one cycle after an edge with WE & FF.
- UDF is registered: 1 for exactly one cycle after an edge with RE & EF.

Read latency (default):
- DOUT is registered. On an accepted read, DOUT <= mem[RADD], valid the cycle after the edge.
- DOUT holds its value otherwise, including on a rejected read.

Optional Feature:
FIFO_FWFT_EN (first-word-fall-through).
- Defined:
  - DOUT is combinational mem[RADD]; the head word is visible whenever EF=0.
  - DOUT is driven 0 when EF=1.
  - RE acknowledges/pops the shown word; the next word appears the cycle after the edge.
  - No DOUT register exists.
- Undefined: the default registered-read behaviour above.
- Flags, COUNT, OVF, UDF and accept rules are identical in both modes.

Decomposition:
- Shared package fifo_pkg holds:
  - function ptr_w(depth) = clog2(depth)+1
  - default constants FIFO_WIDTH_DEF=8, FIFO_DEPTH_DEF=16
- One natural sub-module: fifo_ptr.
  - Parametrised wrap-bit pointer register with enable and async reset.
  - Instantiated twice, for WADD and RADD.
- Memory is inferred inline as a DEPTH x WIDTH array.

Test Plan:
1. Reset: assert RESET mid-stream with COUNT=5 → immediately COUNT=0, EF=1, PEF=1, FF=0, DOUT=0; the next write of 0xA5 then read returns 0xA5.
2. Fill/drain (defaults): write 0x00..0x0F.
   - PFF rises after the 12th write and FF after the 16th, with COUNT=16.
   - Drain 16 reads: data 0x00..0x0F in order. PEF rises when COUNT=4 and EF when COUNT=0.
3. Overflow: FF=1, WE=1 for 2 cycles with DIN=0xEE → OVF high 2 cycles, COUNT stays 16, 0xEE is never read out.
4. Underflow: EF=1, RE=1 for 1 cycle → UDF high 1 cycle, DOUT unchanged, RADD unchanged.
5. Simultaneous and wrap-around:
   - Hold COUNT=8, then assert WE&RE for 40 cycles with an incrementing DIN → COUNT stays 8, output sequence is contiguous across the pointer wrap.
   - Repeat at full (only the read is accepted) and at empty (only the write is accepted).
6. Parameter sweep: WIDTH=16, DEPTH=4, AE_THRESH=1, AF_THRESH=3 → FF after 4 writes, PFF at COUNT=3, PEF at COUNT<=1. Run once with FIFO_FWFT_EN defined: DOUT equals the first word in the cycle after its write edge, with no RE needed.
